// File: rtl/cmp_seq_pkg.sv
// cmp_seq_unit shared types
// State encoding and index-width helper
package cmp_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmp_seq_if.sv
// cmp_seq_unit request/result bundle
// Sequencer drives master, comparator is slave
interface cmp_seq_if #(
  parameter int WIDTH = 16,
  parameter int SW    = 3
);
  import cmp_seq_pkg::*;

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [SW-1:0]    steps;

  modport master (
    output start, signed_mode, op1, op2,
    input  busy, done, eq, gt, lt, steps
  );

  modport slave (
    input  start, signed_mode, op1, op2,
    output busy, done, eq, gt, lt, steps
  );

endinterface

// File: rtl/cmp_chunk.sv
// One-chunk magnitude compare
// Top chunk honours the sign bit in signed mode
module cmp_chunk
  import cmp_seq_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             is_top,
  input  logic             signed_mode,
  output logic             ch_eq,
  output logic             ch_gt,
  output logic             ch_lt
);

  logic w_sdiff;

  assign w_sdiff = is_top & signed_mode &
                   (a[CHUNK-1] ^ b[CHUNK-1]);

  // Negative operand loses when signs differ
  always_comb begin
    ch_eq = 1'b0;
    ch_gt = 1'b0;
    ch_lt = 1'b0;
    if (w_sdiff) begin
      ch_lt = a[CHUNK-1];
      ch_gt = b[CHUNK-1];
    end else begin
      ch_eq = (a == b);
      ch_gt = (a > b);
      ch_lt = (a < b);
    end
  end

endmodule

// File: rtl/cmp_seq_unit.sv
// Multi-cycle MSB-first magnitude comparator
// Stops on the first differing chunk
module cmp_seq_unit
  import cmp_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic      clk,
  input  logic      rst,
  cmp_seq_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_w(NCHUNK);
  localparam int SW     = $clog2(NCHUNK) + 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sm;
  logic [IW-1:0]    r_idx;
  logic [SW-1:0]    r_cnt;
  logic             r_done;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;
  logic [SW-1:0]    r_steps;

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_top;
  logic             w_eq;
  logic             w_gt;
  logic             w_lt;
  logic             w_dec;

  assign w_ca  = r_a[int'(r_idx)*CHUNK +: CHUNK];
  assign w_cb  = r_b[int'(r_idx)*CHUNK +: CHUNK];
  assign w_top = (r_idx == TOP_IDX);
  assign w_dec = !w_eq || (r_idx == '0);

  cmp_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a          (w_ca),
    .b          (w_cb),
    .is_top     (w_top),
    .signed_mode(r_sm),
    .ch_eq      (w_eq),
    .ch_gt      (w_gt),
    .ch_lt      (w_lt)
  );

  // Accept, walk chunks downward, stop on decision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sm    <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= bus.op1;
            r_b     <= bus.op2;
            r_sm    <= bus.signed_mode;
            r_idx   <= TOP_IDX;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + SW'(1);
          if (w_dec) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Result flags held until the next decision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_steps <= '0;
    end else if (r_state == RUN && w_dec) begin
      r_eq    <= w_eq;
      r_gt    <= w_gt;
      r_lt    <= w_lt;
      r_steps <= r_cnt + SW'(1);
    end
  end

  assign bus.busy  = (r_state == RUN);
  assign bus.done  = r_done;
  assign bus.eq    = r_eq;
  assign bus.gt    = r_gt;
  assign bus.lt    = r_lt;
  assign bus.steps = r_steps;

endmodule

// File: tb/tb_cmp_seq_unit.sv
// Directed bench for cmp_seq_unit
// WIDTH=16, CHUNK=4
module tb_cmp_seq_unit;
  import cmp_seq_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   lat;

  cmp_seq_if #(.WIDTH(16), .SW(3)) bus ();

  cmp_seq_unit #(
    .WIDTH(16),
    .CHUNK(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start one compare, count edges until done
  task automatic do_op(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic sm,
                       output int l);
    bus.op1 = a;
    bus.op2 = b;
    bus.signed_mode = sm;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    l = 0;
    while (!bus.done && l < 20) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_chk++;
    if ({bus.busy, bus.done, bus.eq, bus.gt, bus.lt,
         bus.steps} !== 8'h00)
      $display("FAIL reset: got %b want 00000000",
               {bus.busy, bus.done, bus.eq, bus.gt,
                bus.lt, bus.steps});
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_equal();
    do_op(16'h000B, 16'h000B, 1'b0, lat);
    n_chk++;
    if ({bus.eq, bus.gt, bus.lt, bus.steps} !== 6'b100_100)
      $display("FAIL eq_flags: got %b want 100100",
               {bus.eq, bus.gt, bus.lt, bus.steps});
    else n_pass++;
    n_chk++;
    if (lat !== 4)
      $display("FAIL eq_latency: got %0d want 4", lat);
    else n_pass++;
  endtask

  task automatic test_top_chunk();
    do_op(16'hF00F, 16'h0FF0, 1'b0, lat);
    n_chk++;
    if ({bus.eq, bus.gt, bus.lt, bus.steps} !== 6'b010_001)
      $display("FAIL f00f_u: got %b want 010001",
               {bus.eq, bus.gt, bus.lt, bus.steps});
    else n_pass++;
    n_chk++;
    if (lat !== 1)
      $display("FAIL f00f_u_lat: got %0d want 1", lat);
    else n_pass++;
    do_op(16'hF00F, 16'h0FF0, 1'b1, lat);
    n_chk++;
    if ({bus.eq, bus.gt, bus.lt, bus.steps} !== 6'b001_001)
      $display("FAIL f00f_s: got %b want 001001",
               {bus.eq, bus.gt, bus.lt, bus.steps});
    else n_pass++;
    do_op(16'h0000, 16'hFFFF, 1'b0, lat);
    n_chk++;
    if ({bus.eq, bus.gt, bus.lt, bus.steps} !== 6'b001_001)
      $display("FAIL zero_ones_u: got %b want 001001",
               {bus.eq, bus.gt, bus.lt, bus.steps});
    else n_pass++;
    do_op(16'h0000, 16'hFFFF, 1'b1, lat);
    n_chk++;
    if ({bus.eq, bus.gt, bus.lt, bus.steps} !== 6'b010_001)
      $display("FAIL zero_ones_s: got %b want 010001",
               {bus.eq, bus.gt, bus.lt, bus.steps});
    else n_pass++;
    n_chk++;
    if (lat !== 1)
      $display("FAIL zero_ones_s_lat: got %0d want 1", lat);
    else n_pass++;
  endtask

  task automatic test_sign();
    do_op(16'h8000, 16'h7FFF, 1'b1, lat);
    n_chk++;
    if ({bus.eq, bus.gt, bus.lt, bus.steps} !== 6'b001_001)
      $display("FAIL min_max_s: got %b want 001001",
               {bus.eq, bus.gt, bus.lt, bus.steps});
    else n_pass++;
    do_op(16'h8000, 16'h7FFF, 1'b0, lat);
    n_chk++;
    if ({bus.eq, bus.gt, bus.lt, bus.steps} !== 6'b010_001)
      $display("FAIL min_max_u: got %b want 010001",
               {bus.eq, bus.gt, bus.lt, bus.steps});
    else n_pass++;
    do_op(16'h1235, 16'h1234, 1'b0, lat);
    n_chk++;
    if ({bus.eq, bus.gt, bus.lt, bus.steps} !== 6'b010_100)
      $display("FAIL low_chunk: got %b want 010100",
               {bus.eq, bus.gt, bus.lt, bus.steps});
    else n_pass++;
    n_chk++;
    if (lat !== 4)
      $display("FAIL low_chunk_lat: got %0d want 4", lat);
    else n_pass++;
    do_op(16'hFFF0, 16'hFFF1, 1'b1, lat);
    n_chk++;
    if ({bus.eq, bus.gt, bus.lt, bus.steps} !== 6'b001_100)
      $display("FAIL neg_low_s: got %b want 001100",
               {bus.eq, bus.gt, bus.lt, bus.steps});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bus.op1 = 16'h1234;
    bus.op2 = 16'h1234;
    bus.signed_mode = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.op1 = 16'hFFFF;
    bus.signed_mode = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_chk++;
    if (bus.busy !== 1'b1)
      $display("FAIL busy_run: got %b want 1", bus.busy);
    else n_pass++;
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_chk++;
    if ({bus.eq, bus.gt, bus.lt, bus.steps} !== 6'b100_100)
      $display("FAIL ignore_start: got %b want 100100",
               {bus.eq, bus.gt, bus.lt, bus.steps});
    else n_pass++;
    n_chk++;
    if (lat !== 4)
      $display("FAIL ignore_lat: got %0d want 4", lat);
    else n_pass++;
    bus.op1 = 16'h0001;
    bus.op2 = 16'h0000;
    bus.signed_mode = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_chk++;
    if ({bus.done, bus.busy} !== 2'b01)
      $display("FAIL b2b_accept: got %b want 01",
               {bus.done, bus.busy});
    else n_pass++;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_chk++;
    if ({bus.eq, bus.gt, bus.lt, bus.steps} !== 6'b100_100)
      $display("FAIL b2b_hold: got %b want 100100",
               {bus.eq, bus.gt, bus.lt, bus.steps});
    else n_pass++;
    lat = 2;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_chk++;
    if ({bus.eq, bus.gt, bus.lt, bus.steps} !== 6'b010_100)
      $display("FAIL b2b_result: got %b want 010100",
               {bus.eq, bus.gt, bus.lt, bus.steps});
    else n_pass++;
    n_chk++;
    if (lat !== 4)
      $display("FAIL b2b_lat: got %0d want 4", lat);
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if ({bus.done, bus.gt} !== 2'b01)
      $display("FAIL done_pulse: got %b want 01",
               {bus.done, bus.gt});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.op1 = 16'h0001;
    bus.op2 = 16'h0002;
    bus.signed_mode = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({bus.busy, bus.done, bus.eq, bus.gt, bus.lt,
         bus.steps} !== 8'h00)
      $display("FAIL reset_mid: got %b want 00000000",
               {bus.busy, bus.done, bus.eq, bus.gt,
                bus.lt, bus.steps});
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    n_chk++;
    if (seen !== 0)
      $display("FAIL no_done_after_rst: got %0d want 0", seen);
    else n_pass++;
    do_op(16'h0001, 16'h0002, 1'b0, lat);
    n_chk++;
    if ({bus.eq, bus.gt, bus.lt, bus.steps} !== 6'b001_100)
      $display("FAIL post_rst: got %b want 001100",
               {bus.eq, bus.gt, bus.lt, bus.steps});
    else n_pass++;
    n_chk++;
    if (lat !== 4)
      $display("FAIL post_rst_lat: got %0d want 4", lat);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.op1 = '0;
    bus.op2 = '0;
    test_reset();
    test_equal();
    test_top_chunk();
    test_sign();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
